// File: rtl/y86_stage_reg.sv
// Y86-64 pipeline stage register: captures one stage's instruction record per clock,
// with bubble > stall > load priority, saturating stall/bubble counters and a sticky conflict flag.
module y86_stage_reg #(
    parameter int          PAYLOAD_W   = 192,
    parameter logic [3:0]  NOP_ICODE   = 4'h1,
    parameter logic [2:0]  BUBBLE_STAT = 3'd1,
    parameter logic [3:0]  RNONE       = 4'hF,
    parameter int          CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic                 cnt_clr,
    input  logic                 in_valid,
    input  logic [2:0]           in_stat,
    input  logic [3:0]           in_icode,
    input  logic [3:0]           in_ifun,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [3:0]           in_srcA,
    input  logic [3:0]           in_srcB,
    input  logic [3:0]           in_dstE,
    input  logic [3:0]           in_dstM,
    output logic                 out_valid,
    output logic [2:0]           out_stat,
    output logic [3:0]           out_icode,
    output logic [3:0]           out_ifun,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [3:0]           out_srcA,
    output logic [3:0]           out_srcB,
    output logic [3:0]           out_dstE,
    output logic [3:0]           out_dstM,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
    output logic                 conflict
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 valid_q,   valid_d;
    logic [2:0]           stat_q,    stat_d;
    logic [3:0]           icode_q,   icode_d;
    logic [3:0]           ifun_q,    ifun_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [3:0]           src_a_q,   src_a_d;
    logic [3:0]           src_b_q,   src_b_d;
    logic [3:0]           dst_e_q,   dst_e_d;
    logic [3:0]           dst_m_q,   dst_m_d;
    logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;
    logic                 conflict_q,   conflict_d;

    always_comb begin
        valid_d      = valid_q;
        stat_d       = stat_q;
        icode_d      = icode_q;
        ifun_d       = ifun_q;
        payload_d    = payload_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        dst_e_d      = dst_e_q;
        dst_m_d      = dst_m_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        conflict_d   = conflict_q;

        if (bubble) begin
            // NOP record uses RNONE destinations so forwarding never matches a bubble
            valid_d   = 1'b0;
            stat_d    = BUBBLE_STAT;
            icode_d   = NOP_ICODE;
            ifun_d    = 4'h0;
            payload_d = '0;
            src_a_d   = RNONE;
            src_b_d   = RNONE;
            dst_e_d   = RNONE;
            dst_m_d   = RNONE;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
            if (stall) begin
                conflict_d = 1'b1;
            end
        end else if (stall) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end else begin
            valid_d   = in_valid;
            stat_d    = in_stat;
            icode_d   = in_icode;
            ifun_d    = in_ifun;
            payload_d = in_payload;
            src_a_d   = in_srcA;
            src_b_d   = in_srcB;
            dst_e_d   = in_dstE;
            dst_m_d   = in_dstM;
        end

        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            stat_q       <= BUBBLE_STAT;
            icode_q      <= NOP_ICODE;
            ifun_q       <= 4'h0;
            payload_q    <= '0;
            src_a_q      <= RNONE;
            src_b_q      <= RNONE;
            dst_e_q      <= RNONE;
            dst_m_q      <= RNONE;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            conflict_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            stat_q       <= stat_d;
            icode_q      <= icode_d;
            ifun_q       <= ifun_d;
            payload_q    <= payload_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            dst_e_q      <= dst_e_d;
            dst_m_q      <= dst_m_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            conflict_q   <= conflict_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_stat    = stat_q;
    assign out_icode   = icode_q;
    assign out_ifun    = ifun_q;
    assign out_payload = payload_q;
    assign out_srcA    = src_a_q;
    assign out_srcB    = src_b_q;
    assign out_dstE    = dst_e_q;
    assign out_dstM    = dst_m_q;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign conflict    = conflict_q;

endmodule

// File: tb/tb_y86_stage_reg.sv
// Scoreboard bench for y86_stage_reg: a behavioural model pushes the expected record and
// statistics each edge; scenario tasks pop and compare after the edge.
module tb_y86_stage_reg;

   typedef struct packed {
      logic         valid;
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [191:0] payload;
      logic [3:0]   src_a;
      logic [3:0]   src_b;
      logic [3:0]   dst_e;
      logic [3:0]   dst_m;
   } rec_t;

   typedef struct packed {
      rec_t        rec;
      logic [15:0] sc;
      logic [15:0] bc;
      logic        cf;
   } exp_t;

   localparam rec_t NOP_REC = '{valid: 1'b0, stat: 3'd1, icode: 4'h1, ifun: 4'h0,
                                payload: 192'd0, src_a: 4'hF, src_b: 4'hF,
                                dst_e: 4'hF, dst_m: 4'hF};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic stall = 1'b0;
   logic bubble = 1'b0;
   logic cnt_clr = 1'b0;
   rec_t in_r = '0;

   logic         out_valid;
   logic [2:0]   out_stat;
   logic [3:0]   out_icode, out_ifun, out_srcA, out_srcB, out_dstE, out_dstM;
   logic [191:0] out_payload;
   logic [15:0]  stall_cnt, bubble_cnt;
   logic         conflict;

   logic         sm_valid;
   logic [2:0]   sm_stat;
   logic [3:0]   sm_icode, sm_ifun, sm_srcA, sm_srcB, sm_dstE, sm_dstM;
   logic [191:0] sm_payload;
   logic [1:0]   sm_stall_cnt, sm_bubble_cnt;
   logic         sm_conflict;

   rec_t dut_rec, sm_rec;
   exp_t dut_full;
   assign dut_rec  = {out_valid, out_stat, out_icode, out_ifun, out_payload,
                      out_srcA, out_srcB, out_dstE, out_dstM};
   assign sm_rec   = {sm_valid, sm_stat, sm_icode, sm_ifun, sm_payload,
                      sm_srcA, sm_srcB, sm_dstE, sm_dstM};
   assign dut_full = {dut_rec, stall_cnt, bubble_cnt, conflict};

   y86_stage_reg dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
      .in_valid(in_r.valid), .in_stat(in_r.stat), .in_icode(in_r.icode),
      .in_ifun(in_r.ifun), .in_payload(in_r.payload), .in_srcA(in_r.src_a),
      .in_srcB(in_r.src_b), .in_dstE(in_r.dst_e), .in_dstM(in_r.dst_m),
      .out_valid(out_valid), .out_stat(out_stat), .out_icode(out_icode),
      .out_ifun(out_ifun), .out_payload(out_payload), .out_srcA(out_srcA),
      .out_srcB(out_srcB), .out_dstE(out_dstE), .out_dstM(out_dstM),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .conflict(conflict)
   );

   y86_stage_reg #(.CNT_W(2)) dut_sm (
      .clk(clk), .rst_n(rst_n), .stall(stall), .bubble(bubble), .cnt_clr(cnt_clr),
      .in_valid(in_r.valid), .in_stat(in_r.stat), .in_icode(in_r.icode),
      .in_ifun(in_r.ifun), .in_payload(in_r.payload), .in_srcA(in_r.src_a),
      .in_srcB(in_r.src_b), .in_dstE(in_r.dst_e), .in_dstM(in_r.dst_m),
      .out_valid(sm_valid), .out_stat(sm_stat), .out_icode(sm_icode),
      .out_ifun(sm_ifun), .out_payload(sm_payload), .out_srcA(sm_srcA),
      .out_srcB(sm_srcB), .out_dstE(sm_dstE), .out_dstM(sm_dstM),
      .stall_cnt(sm_stall_cnt), .bubble_cnt(sm_bubble_cnt), .conflict(sm_conflict)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t sb[$];
   rec_t m_rec;
   logic [15:0] m_sc, m_bc;
   logic m_cf;

   function automatic rec_t rand_rec();
      rec_t r;
      r.valid   = 1'($urandom_range(0, 1));
      r.stat    = 3'($urandom_range(0, 7));
      r.icode   = 4'($urandom_range(0, 15));
      r.ifun    = 4'($urandom_range(0, 15));
      r.payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r.src_a   = 4'($urandom_range(0, 15));
      r.src_b   = 4'($urandom_range(0, 15));
      r.dst_e   = 4'($urandom_range(0, 14));
      r.dst_m   = 4'($urandom_range(0, 14));
      return r;
   endfunction

   task automatic model_reset();
      m_rec = NOP_REC;
      m_sc  = 16'd0;
      m_bc  = 16'd0;
      m_cf  = 1'b0;
      sb.delete();
   endtask

   // Drive one edge's controls and inputs; the model's post-edge state goes to the scoreboard
   task automatic drive_edge(input logic st, input logic bb, input logic clr, input rec_t r);
      stall   = st;
      bubble  = bb;
      cnt_clr = clr;
      in_r    = r;
      if (bb) begin
         m_rec = NOP_REC;
         if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
         if (st) m_cf = 1'b1;
      end else if (st) begin
         if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      end else begin
         m_rec = r;
      end
      if (clr) begin
         m_sc = 16'd0;
         m_bc = 16'd0;
      end
      sb.push_back('{rec: m_rec, sc: m_sc, bc: m_bc, cf: m_cf});
      @(posedge clk);
      #1;
      stall   = 1'b0;
      bubble  = 1'b0;
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rec_t r;
      rst_n = 1'b0;
      in_r  = rand_rec();
      stall = 1'b1;
      #2;
      n_cmp++;
      if (dut_rec !== NOP_REC) begin
         n_fail++;
         $display("[TB] FAIL reset_record: got %h expected %h", dut_rec, NOP_REC);
      end
      n_cmp++;
      if ({stall_cnt, bubble_cnt, conflict} !== 33'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_stats: got %h expected 0", {stall_cnt, bubble_cnt, conflict});
      end
      stall = 1'b0;
      rst_n = 1'b1;
      model_reset();
      r = rand_rec();
      drive_edge(1'b0, 1'b0, 1'b0, r);
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL release_load: got %h expected %h", dut_full, e);
      end
      n_cmp++;
      if (dut_rec !== r) begin
         n_fail++;
         $display("[TB] FAIL release_equals_input: got %h expected %h", dut_rec, r);
      end
   endtask

   task automatic test_load_stall();
      exp_t e;
      rec_t r;
      r = rand_rec();
      r.icode   = 4'h6;
      r.payload = 192'h1234;
      drive_edge(1'b0, 1'b0, 1'b0, r);
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL load: got %h expected %h", dut_full, e);
      end
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'b1, 1'b0, 1'b0, rand_rec());
         e = sb.pop_front();
         n_cmp++;
         if (dut_full !== e) begin
            n_fail++;
            $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, dut_full, e);
         end
         n_cmp++;
         if ({out_icode, out_payload} !== {4'h6, 192'h1234}) begin
            n_fail++;
            $display("[TB] FAIL stall_fields_%0d: got icode %h payload %h expected 6 1234",
                     i, out_icode, out_payload);
         end
      end
      n_cmp++;
      if (stall_cnt !== 16'd3) begin
         n_fail++;
         $display("[TB] FAIL stall_cnt: got %0d expected 3", stall_cnt);
      end
   endtask

   task automatic test_bubble();
      exp_t e;
      rec_t r;
      r = rand_rec();
      r.valid = 1'b1;
      r.dst_e = 4'h3;
      drive_edge(1'b0, 1'b0, 1'b0, r);
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL bubble_preload: got %h expected %h", dut_full, e);
      end
      drive_edge(1'b0, 1'b1, 1'b0, rand_rec());
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL bubble_record: got %h expected %h", dut_full, e);
      end
      n_cmp++;
      if ({out_icode, out_dstE, out_dstM, out_valid, bubble_cnt} !== {4'h1, 4'hF, 4'hF, 1'b0, 16'd1}) begin
         n_fail++;
         $display("[TB] FAIL bubble_fields: got icode %h dstE %h dstM %h valid %b bcnt %0d expected 1 f f 0 1",
                  out_icode, out_dstE, out_dstM, out_valid, bubble_cnt);
      end
      r = rand_rec();
      drive_edge(1'b0, 1'b0, 1'b0, r);
      e = sb.pop_front();
      n_cmp++;
      if (dut_rec !== r) begin
         n_fail++;
         $display("[TB] FAIL after_bubble_load: got %h expected %h", dut_rec, r);
      end
   endtask

   task automatic test_conflict();
      exp_t e;
      drive_edge(1'b0, 1'b0, 1'b0, rand_rec());
      void'(sb.pop_front());
      drive_edge(1'b1, 1'b1, 1'b0, rand_rec());
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL conflict_edge: got %h expected %h", dut_full, e);
      end
      n_cmp++;
      if ({conflict, stall_cnt, bubble_cnt, dut_rec} !== {1'b1, 16'd3, 16'd2, NOP_REC}) begin
         n_fail++;
         $display("[TB] FAIL conflict_stats: got cf %b scnt %0d bcnt %0d expected 1 3 2",
                  conflict, stall_cnt, bubble_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         drive_edge(1'(i == 1), 1'b0, 1'(i == 2), rand_rec());
         e = sb.pop_front();
         n_cmp++;
         if (dut_full !== e || conflict !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL conflict_sticky_%0d: got %h expected %h", i, dut_full, e);
         end
      end
   endtask

   task automatic test_async_reset_mid_stall();
      exp_t e;
      drive_edge(1'b0, 1'b0, 1'b0, rand_rec());
      void'(sb.pop_front());
      drive_edge(1'b1, 1'b0, 1'b0, rand_rec());
      void'(sb.pop_front());
      stall = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (dut_full !== {NOP_REC, 33'd0}) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got %h expected %h", dut_full, {NOP_REC, 33'd0});
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (dut_full !== {NOP_REC, 33'd0}) begin
         n_fail++;
         $display("[TB] FAIL reset_held_over_edge: got %h expected %h", dut_full, {NOP_REC, 33'd0});
      end
      rst_n = 1'b1;
      model_reset();
      drive_edge(1'b1, 1'b0, 1'b0, rand_rec());
      e = sb.pop_front();
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL stall_after_release: got %h expected %h", dut_full, e);
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      rec_t r;
      logic [1:0] want;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      model_reset();
      r = rand_rec();
      drive_edge(1'b0, 1'b0, 1'b0, r);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         drive_edge(1'b1, 1'b0, 1'b0, rand_rec());
         e = sb.pop_front();
         want = (i >= 2) ? 2'd3 : 2'(i + 1);
         n_cmp++;
         if (sm_stall_cnt !== want || dut_full !== e) begin
            n_fail++;
            $display("[TB] FAIL sat_stall_%0d: got %0d expected %0d", i, sm_stall_cnt, want);
         end
      end
      drive_edge(1'b1, 1'b0, 1'b1, rand_rec());
      e = sb.pop_front();
      n_cmp++;
      if (sm_stall_cnt !== 2'd0 || sm_rec !== r) begin
         n_fail++;
         $display("[TB] FAIL clr_with_stall: got cnt %0d rec %h expected 0 %h", sm_stall_cnt, sm_rec, r);
      end
      n_cmp++;
      if (dut_full !== e) begin
         n_fail++;
         $display("[TB] FAIL clr_main: got %h expected %h", dut_full, e);
      end
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b0, 1'b1, 1'b0, rand_rec());
         void'(sb.pop_front());
         want = (i >= 2) ? 2'd3 : 2'(i + 1);
         n_cmp++;
         if (sm_bubble_cnt !== want) begin
            n_fail++;
            $display("[TB] FAIL sat_bubble_%0d: got %0d expected %0d", i, sm_bubble_cnt, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 24; i++) begin
         drive_edge(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 9) == 0), rand_rec());
         e = sb.pop_front();
         n_cmp++;
         if (dut_full !== e) begin
            n_fail++;
            $display("[TB] FAIL b2b_%0d: got %h expected %h", i, dut_full, e);
         end
      end
   endtask

   // Run every scenario in order, then report how many comparisons were made and how many failed
   initial begin
      test_reset();
      test_load_stall();
      test_bubble();
      test_conflict();
      test_async_reset_mid_stall();
      test_saturation();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
